cpu_debug_scan_master: RTL

- Host-side initiator for the Nios II debug slave's virtual-JTAG data path.
- Converts one command (2-bit IR plus DR_WIDTH-bit shift payload) into a full scan sequence: UIR, CDR, SDR×DR_WIDTH, UDR, RTI.
- Drives a generated tck, collects tdo, and returns the captured DR word.
- Used in simulation benches and in the on-chip self-test path to exercise the debug slave without an external JTAG cable.

---
 rtl/cpu_debug_scan_master.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator: turns one IR/DR command into UIR,CDR,SDRxN,UDR,RTI on a generated tck.
// Optional IR cache that skips redundant UIR phases: define DEBUG_SCAN_IR_CACHE_EN.

module cpu_debug_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [1:0]          ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BW = $clog2(DR_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RTI
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tck_q, tck_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] rx_q, rx_d;
  logic [BW-1:0]       bits_q, bits_d;
  logic [1:0]          ir_q, ir_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                live_q;
  logic                tick, rise, fall, accept, skip_uir;

`ifdef DEBUG_SCAN_IR_CACHE_EN
  logic [1:0] last_ir_q, last_ir_d;
  logic       ir_hit_q, ir_hit_d;
  assign skip_uir = ir_hit_q && (cmd_ir == last_ir_q);
`else
  assign skip_uir = 1'b0;
`endif

  // live_q keeps cmd_ready low while reset is held and until the first edge after release
  assign cmd_ready = live_q && (state_q == S_IDLE) && !rsp_valid_q;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (cnt_q == CW'(TCK_DIV - 1));
  assign rise      = (state_q != S_IDLE) && tick && !tck_q;
  assign fall      = (state_q != S_IDLE) && tick && tck_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tck_d       = tck_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bits_d      = bits_q;
    ir_d        = ir_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef DEBUG_SCAN_IR_CACHE_EN
    last_ir_d   = last_ir_q;
    ir_hit_d    = ir_hit_q;
`endif

    if (state_q == S_IDLE) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) tck_d = ~tck_q;
    end

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tx_d   = cmd_data;
          rx_d   = '0;
          bits_d = '0;
          if (skip_uir) begin
            state_d = S_CDR;
          end else begin
            state_d = S_UIR;
            ir_d    = cmd_ir;
`ifdef DEBUG_SCAN_IR_CACHE_EN
            last_ir_d = cmd_ir;
            ir_hit_d  = 1'b1;
`endif
          end
        end
      end
      S_UIR: if (fall) state_d = S_CDR;
      S_CDR: if (fall) state_d = S_SDR;
      // Capture on tck rise, advance payload on tck fall; leave after the last captured bit
      S_SDR: begin
        if (rise) begin
          rx_d   = {tdo, rx_q[DR_WIDTH-1:1]};
          bits_d = bits_q + 1'b1;
        end
        if (fall) begin
          tx_d = tx_q >> 1;
          if (bits_q == BW'(DR_WIDTH)) state_d = S_UDR;
        end
      end
      S_UDR: if (fall) state_d = S_RTI;
      S_RTI: begin
        if (fall) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      bits_q      <= '0;
      ir_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      live_q      <= 1'b0;
`ifdef DEBUG_SCAN_IR_CACHE_EN
      last_ir_q   <= '0;
      ir_hit_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tck_q       <= tck_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bits_q      <= bits_d;
      ir_q        <= ir_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      live_q      <= 1'b1;
`ifdef DEBUG_SCAN_IR_CACHE_EN
      last_ir_q   <= last_ir_d;
      ir_hit_q    <= ir_hit_d;
`endif
    end
  end

  // Strobes and tdi decode from state, which only moves on tck fall or accept
  assign tck            = tck_q;
  assign tdi            = (state_q == S_SDR) ? tx_q[0] : 1'b0;
  assign ir_out         = ir_q;
  assign vs_uir         = (state_q == S_UIR);
  assign vs_cdr         = (state_q == S_CDR);
  assign vs_sdr         = (state_q == S_SDR);
  assign vs_udr         = (state_q == S_UDR);
  assign jtag_state_rti = (state_q == S_RTI);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;

endmodule
